// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS lane receiver: bit-slip alignment on control-token runs, symbol decode; 2-edge latency, no backpressure.
// Optional build macro TMDS_DECODER_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter output (loss_count).
module tmds_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096
) (
  input  logic       pix_clk,
  input  logic       resetn,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_DECODER_LOSS_CNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam logic [7:0]  RUN_TARGET   = 8'(CTRL_RUN);
  localparam logic [15:0] TIMEOUT_LAST = 16'(SEARCH_TIMEOUT - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [9:0]  prev, sym, sym_d;
  logic [19:0] window;
  logic [7:0]  run, run_inc;
  logic [15:0] timer;
  logic        is_tok, run_done, timeout, slip;
  logic [1:0]  tok_c;
  logic [7:0]  d, dec;

  // Stage 1: capture the raw word and the symbol at the current slip offset.
  assign window = {tmds_word, prev};
  assign sym_d  = window[offset +: 10];

  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      prev <= '0;
      sym  <= '0;
    end else begin
      prev <= tmds_word;
      sym  <= sym_d;
    end
  end

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (sym)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  always_comb begin
    d      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // A completed run wins over a coincident timeout: no slip, no lock loss.
  assign run_inc  = run + 8'd1;
  assign run_done = is_tok && (run_inc == RUN_TARGET);
  assign timeout  = (timer == TIMEOUT_LAST);
  assign slip     = (state == SEARCH) && !run_done && timeout;

  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (run_done) state_nxt = LOCKED;
      LOCKED:  if (!run_done && timeout) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      run    <= '0;
      timer  <= '0;
      offset <= '0;
    end else begin
      if (run_done || timeout) begin
        run   <= '0;
        timer <= '0;
      end else begin
        run   <= is_tok ? run_inc : 8'd0;
        timer <= timer + 16'd1;
      end
      if (slip)
        offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    end
  end

  // Stage 2: gated by the pre-edge state, so the locking token itself stays zeroed.
  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      data <= '0;
      de   <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else if (state != LOCKED) begin
      data <= '0;
      de   <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else if (is_tok) begin
      data <= '0;
      de   <= 1'b0;
      c0   <= tok_c[0];
      c1   <= tok_c[1];
    end else begin
      data <= dec;
      de   <= 1'b1;
    end
  end

`ifdef TMDS_DECODER_LOSS_CNT_EN
  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn)
      loss_count <= '0;
    else if ((state == LOCKED) && (state_nxt == SEARCH) && (loss_count != 8'hFF))
      loss_count <= loss_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with CTRL_RUN=8, SEARCH_TIMEOUT=64.
// Edge numbers count posedges after reset release; word k is sampled on edge k.
module tb_tmds_decoder;
  logic       pix_clk = 1'b0;
  logic       resetn;
  logic [9:0] tmds_word;
  logic [7:0] data;
  logic       de, c0, c1, locked;
  logic [3:0] offset;
`ifdef TMDS_DECODER_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int e, e_o1, e_o2, e_o3, e_lock, e_fall, e_w0, e_w1, e_relock;
  logic de_after_fall;
  logic [3:0] off_at_fall;

  tmds_decoder #(.CTRL_RUN(8), .SEARCH_TIMEOUT(64)) dut (
    .pix_clk   (pix_clk),
    .resetn    (resetn),
    .tmds_word (tmds_word),
    .data      (data),
    .de        (de),
    .c0        (c0),
    .c1        (c1),
    .locked    (locked),
    .offset    (offset)
`ifdef TMDS_DECODER_LOSS_CNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge pix_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    tmds_word = 10'h000;
    @(posedge pix_clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    tmds_word = 10'h000;
    #1;
    check("rst_data",   16'(data),   16'h0);
    check("rst_de",     16'(de),     16'h0);
    check("rst_locked", 16'(locked), 16'h0);
    check("rst_offset", 16'(offset), 16'h0);

    // Aligned lock: 12 x 0x354, then 0x100, 0x2FF at offset 0.
    do_reset();
    for (int k = 1; k <= 9; k++) step(10'h354);
    check("al_nolock_e9", 16'(locked), 16'h0);
    step(10'h354);
    check("al_lock_e10", 16'(locked), 16'h1);
    check("al_lock_de",  16'(de),     16'h0);
    step(10'h354);
    check("al_c_e11", 16'({c1, c0}), 16'h0);
    check("al_de_e11", 16'(de), 16'h0);
    step(10'h354);
    step(10'h100);
    step(10'h2FF);
    step(10'h354);
    check("al_de_e15",   16'(de),   16'h1);
    check("al_data_e15", 16'(data), 16'h00);
    step(10'h354);
    check("al_de_e16",   16'(de),   16'h1);
    check("al_data_e16", 16'(data), 16'hFE);
    step(10'h354);
    check("al_de_e17",   16'(de),   16'h0);
    check("al_data_e17", 16'(data), 16'h00);

    // Broken run: 7 x 0x154, 0x100, 8 x 0x154, then more tokens and one data word.
    do_reset();
    for (int k = 1; k <= 7; k++) step(10'h154);
    step(10'h100);
    step(10'h154);
    check("br_nolock_e9", 16'(locked), 16'h0);
    step(10'h154);
    check("br_nolock_e10", 16'(locked), 16'h0);
    for (int k = 11; k <= 16; k++) step(10'h154);
    step(10'h154);
    check("br_nolock_e17", 16'(locked), 16'h0);
    step(10'h100);
    check("br_lock_e18", 16'(locked), 16'h1);
    step(10'h154);
    check("br_c_e19",  16'({c1, c0}), 16'h2);
    check("br_de_e19", 16'(de), 16'h0);
    step(10'h154);
    check("br_de_e20",    16'(de),        16'h1);
    check("br_data_e20",  16'(data),      16'h00);
    check("br_chold_e20", 16'({c1, c0}),  16'h2);

    // Mid-stream reset while locked with de=1 and c1=1.
    #2;
    resetn = 1'b0;
    #1;
    check("mr_de",     16'(de),         16'h0);
    check("mr_c",      16'({c1, c0}),   16'h0);
    check("mr_data",   16'(data),       16'h0);
    check("mr_locked", 16'(locked),     16'h0);
    check("mr_offset", 16'(offset),     16'h0);
    @(posedge pix_clk);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(10'h100);
      check("mr_quiet_de", 16'({locked, de}), 16'h0);
    end

    // Misaligned: 0x2AB stream shifted to window bit 3 (word = rotl(0x2AB,3) = 0x15D).
    do_reset();
    e_o1 = -1; e_o2 = -1; e_o3 = -1; e_lock = -1;
    for (int k = 1; k <= 260; k++) begin
      step(10'h15D);
      if (offset == 4'd1 && e_o1 < 0) e_o1 = k;
      if (offset == 4'd2 && e_o2 < 0) e_o2 = k;
      if (offset == 4'd3 && e_o3 < 0) e_o3 = k;
      if (locked && e_lock < 0) e_lock = k;
    end
    check("ma_off1_edge", 16'(e_o1),   16'd64);
    check("ma_off2_edge", 16'(e_o2),   16'd128);
    check("ma_off3_edge", 16'(e_o3),   16'd192);
    check("ma_lock_edge", 16'(e_lock), 16'd201);
    check("ma_offset",    16'(offset), 16'd3);
    check("ma_c",         16'({c1, c0}), 16'h3);

    // Loss and wrap: lock at offset 9 (word 0x1AA), then shift stream to offset 1 (word 0x2A9).
    do_reset();
    e = 0;
    while (!locked && e < 700) begin
      step(10'h1AA);
      e++;
    end
    check("lw_lock_edge", 16'(e),      16'd585);
    check("lw_offset9",   16'(offset), 16'd9);
    e_fall = -1; e_w0 = -1; e_w1 = -1; e_relock = -1;
    de_after_fall = 1'b1; off_at_fall = 4'hF;
    for (int k = 1; k <= 260; k++) begin
      step(10'h2A9);
      if (!locked && e_fall < 0) begin
        e_fall = k;
        off_at_fall = offset;
      end
      if (k == 65) de_after_fall = de;
      if (offset == 4'd0 && e_w0 < 0) e_w0 = k;
      if (offset == 4'd1 && e_w1 < 0) e_w1 = k;
      if (locked && e_fall > 0 && e_relock < 0) e_relock = k;
    end
    check("lw_fall_edge",   16'(e_fall),        16'd64);
    check("lw_fall_offset", 16'(off_at_fall),   16'd9);
    check("lw_fall_de",     16'(de_after_fall), 16'h0);
    check("lw_wrap0_edge",  16'(e_w0),          16'd128);
    check("lw_off1_edge",   16'(e_w1),          16'd192);
    check("lw_relock_edge", 16'(e_relock),      16'd201);
    check("lw_c",           16'({c1, c0}),      16'h0);
`ifdef TMDS_DECODER_LOSS_CNT_EN
    check("lw_loss_count",  16'(loss_count),    16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
